// File: rtl/peripheral_req2ahb4.sv
// peripheral_req2ahb4
// Converts a simple request/response interface into AHB single transfers.
// The bridge keeps a two-stage pipeline: an address-phase slot (AP) and a
// data-phase slot (DP). Requests are accepted whenever HREADY is high.
// Misaligned requests still move through both slots so that responses stay
// in order. They are never put on the bus and they return an error.
//
// Ports
//   HRESETn, HCLK        async active-low reset, rising-edge clock
//   req_*                request: valid, write, address, right-aligned
//                        write data, HSIZE-encoded size; req_ready_o
//   rsp_*                one-cycle response: valid, right-aligned read
//                        data, error
//   H*                   AHB master signals (single transfers only)
module peripheral_req2ahb4 #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input  logic            HRESETn,
  input  logic            HCLK,

  input  logic            req_i,
  input  logic            req_we_i,
  input  logic [PLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [2:0]      req_size_i,
  output logic            req_ready_o,

  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,

  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,

  input  logic [XLEN-1:0] HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);

  localparam int         BYTES    = XLEN / 8;
  localparam int         LSZ      = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int         OFFW     = (LSZ > 0) ? LSZ : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LSZ);

  // Address-phase slot. HADDR, HWRITE and HSIZE are the AP fields.
  logic            ap_valid;
  logic            ap_mis;
  logic [OFFW-1:0] ap_off;
  logic [XLEN-1:0] ap_wdata;

  // Data-phase slot.
  logic            dp_valid;
  logic            dp_we;
  logic            dp_mis;
  logic [OFFW-1:0] dp_off;
  logic [2:0]      dp_size;

  logic [OFFW-1:0] req_off;
  logic [PLEN-1:0] req_amask;
  logic            req_mis;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] rd_mask;
  logic [XLEN-1:0] rd_data;

  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  assign req_ready_o = HREADY;

  // For an 8-bit bus the byte offset is always zero.
  assign req_off   = (BYTES > 1) ? req_addr_i[OFFW-1:0] : '0;
  assign req_amask = ~({PLEN{1'b1}} << req_size_i);
  assign req_mis   = (req_size_i > MAX_SIZE) || ((req_addr_i & req_amask) != '0);

  assign HTRANS = (ap_valid && !ap_mis) ? 2'b10 : 2'b00;
  assign HSEL   = ap_valid && !ap_mis;

  // A shift of XLEN or more gives zero, so a full-width access gets an
  // all-ones mask.
  assign rd_shift = HRDATA >> {dp_off, 3'b000};
  assign rd_mask  = ~({XLEN{1'b1}} << (11'd8 << dp_size));
  assign rd_data  = rd_shift & rd_mask;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid    <= 1'b0;
      ap_mis      <= 1'b0;
      ap_off      <= '0;
      ap_wdata    <= '0;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'b000;
      dp_valid    <= 1'b0;
      dp_we       <= 1'b0;
      dp_mis      <= 1'b0;
      dp_off      <= '0;
      dp_size     <= 3'b000;
      HWDATA      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else if (HREADY) begin
      dp_valid <= ap_valid;
      dp_we    <= HWRITE;
      dp_mis   <= ap_mis;
      dp_off   <= ap_off;
      dp_size  <= HSIZE;
      HWDATA   <= (ap_valid && HWRITE && !ap_mis) ? ap_wdata : '0;

      ap_valid <= req_i;
      if (req_i) begin
        HADDR    <= req_addr_i;
        HWRITE   <= req_we_i;
        HSIZE    <= req_size_i;
        ap_mis   <= req_mis;
        ap_off   <= req_off;
        // Write data is lane-aligned at acceptance so the DP register only
        // has to copy it.
        ap_wdata <= req_wdata_i << {req_off, 3'b000};
      end

      rsp_valid_o <= dp_valid;
      rsp_err_o   <= dp_valid && (HRESP || dp_mis);
      rsp_rdata_o <= (dp_valid && !dp_we && !HRESP && !dp_mis) ? rd_data : '0;
    end else begin
      // The slave is stalling. The pipeline and bus outputs hold their
      // values, and no response completes this cycle.
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end
  end

endmodule

// File: tb/tb_peripheral_req2ahb4.sv
// Directed testbench for peripheral_req2ahb4 (PLEN=8, XLEN=32).
// Inputs change on the falling edge. Outputs are sampled on the falling
// edge, or #1 after an input change for combinational paths.
module tb_peripheral_req2ahb4;

  logic        HRESETn, HCLK;
  logic        req_i, req_we_i;
  logic [7:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_size_i;
  logic        req_ready_o;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        HSEL, HWRITE, HMASTLOCK;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY, HRESP;

  int n_chk  = 0;
  int n_pass = 0;

  peripheral_req2ahb4 #(.PLEN(8), .XLEN(32)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_size_i(req_size_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] hrdata;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  // Runs one isolated transfer with zero wait states. It starts and ends on
  // a falling edge.
  task automatic run_vec(input int i, input vec_t v);
    req_i = 1'b1; req_we_i = v.we; req_addr_i = v.addr;
    req_wdata_i = v.wdata; req_size_i = v.size;
    HRDATA = v.hrdata; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk($sformatf("v%0d htrans", i), HTRANS, v.htrans);
    chk($sformatf("v%0d hsel", i), HSEL, (v.htrans == 2'b10));
    chk($sformatf("v%0d haddr", i), HADDR, v.addr);
    chk($sformatf("v%0d hsize", i), HSIZE, v.size);
    chk($sformatf("v%0d hwrite", i), HWRITE, v.we);
    chk($sformatf("v%0d rsp_early", i), rsp_valid_o, 1'b0);
    req_i = 1'b0;
    @(negedge HCLK);
    chk($sformatf("v%0d hwdata", i), HWDATA, v.hwdata);
    chk($sformatf("v%0d rsp_early2", i), rsp_valid_o, 1'b0);
    @(negedge HCLK);
    chk($sformatf("v%0d rsp_valid", i), rsp_valid_o, 1'b1);
    chk($sformatf("v%0d rsp_err", i), rsp_err_o, v.err);
    chk($sformatf("v%0d rsp_rdata", i), rsp_rdata_o, v.rdata);
  endtask

  logic        a_rdy[8];
  logic [31:0] a_hrd[8];
  logic        a_rv[8];
  int          idx;

  initial begin
    //          we    addr   wdata          sz    hrdata         htr    hwdata         rdata          err
    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 3'd2, 32'hFFFFFFFF, 2'b10, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 8'h13, 32'h0,        3'd0, 32'hAB000000, 2'b10, 32'h0,        32'h000000AB, 1'b0};
    vecs[2]  = '{1'b1, 8'h02, 32'h00001234, 3'd1, 32'hFFFFFFFF, 2'b10, 32'h12340000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 8'h06, 32'h0,        3'd1, 32'hCAFE1234, 2'b10, 32'h0,        32'h0000CAFE, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 32'h0,        3'd2, 32'h89ABCDEF, 2'b10, 32'h0,        32'h89ABCDEF, 1'b0};
    vecs[5]  = '{1'b0, 8'h01, 32'h0,        3'd2, 32'hFFFFFFFF, 2'b00, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b1, 8'h08, 32'h12345678, 3'd3, 32'hFFFFFFFF, 2'b00, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, 8'h41, 32'h0000005A, 3'd0, 32'hFFFFFFFF, 2'b10, 32'h00005A00, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 8'h03, 32'h0,        3'd1, 32'hFFFFFFFF, 2'b00, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b0, 8'h00, 32'h0,        3'd0, 32'h112233C4, 2'b10, 32'h0,        32'h000000C4, 1'b0};
    vecs[10] = '{1'b0, 8'h05, 32'h0,        3'd0, 32'h00007700, 2'b10, 32'h0,        32'h00000077, 1'b0};

    HRESETn = 1'b0; req_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_size_i = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst htrans", HTRANS, 2'b00);
    chk("rst hsel", HSEL, 1'b0);
    chk("rst haddr", HADDR, 8'h00);
    chk("rst hwdata", HWDATA, 32'h0);
    chk("rst rsp_valid", rsp_valid_o, 1'b0);
    chk("const hburst", HBURST, 3'b000);
    chk("const hprot", HPROT, 4'b0011);
    chk("const hmastlock", HMASTLOCK, 1'b0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Four back-to-back word reads. The second read's data phase has two
    // wait states.
    a_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a_hrd = '{32'h0, 32'h0, 32'hA0A0A0A0, 32'h0, 32'h0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    a_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      HREADY = a_rdy[c]; HRDATA = a_hrd[c];
      req_i = (idx < 4); req_we_i = 1'b0; req_size_i = 3'd2;
      req_addr_i = 8'(8'h40 + 4 * idx);
      #1 chk($sformatf("b2b c%0d req_ready", c), req_ready_o, a_rdy[c]);
      @(posedge HCLK);
      if (req_i && HREADY) idx++;
      @(negedge HCLK);
      chk($sformatf("b2b c%0d rsp_valid", c), rsp_valid_o, a_rv[c]);
      chk($sformatf("b2b c%0d rsp_rdata", c), rsp_rdata_o, a_rv[c] ? a_hrd[c] : 32'h0);
    end
    chk("b2b accepted", idx, 4);
    req_i = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);
    chk("b2b drained", rsp_valid_o, 1'b0);

    // A misaligned word request between two writes.
    req_i = 1'b1; req_we_i = 1'b1; req_size_i = 3'd2;
    req_addr_i = 8'h10; req_wdata_i = 32'h11111111;
    @(negedge HCLK);
    chk("mis w0 htrans", HTRANS, 2'b10);
    req_addr_i = 8'h01; req_wdata_i = 32'h22222222;
    @(negedge HCLK);
    chk("mis m htrans", HTRANS, 2'b00);
    chk("mis m hsel", HSEL, 1'b0);
    chk("mis w0 hwdata", HWDATA, 32'h11111111);
    req_addr_i = 8'h14; req_wdata_i = 32'h33333333;
    @(negedge HCLK);
    req_i = 1'b0;
    chk("mis w1 htrans", HTRANS, 2'b10);
    chk("mis m hwdata", HWDATA, 32'h0);
    chk("mis w0 rsp_valid", rsp_valid_o, 1'b1);
    chk("mis w0 rsp_err", rsp_err_o, 1'b0);
    @(negedge HCLK);
    chk("mis idle htrans", HTRANS, 2'b00);
    chk("mis w1 hwdata", HWDATA, 32'h33333333);
    chk("mis m rsp_valid", rsp_valid_o, 1'b1);
    chk("mis m rsp_err", rsp_err_o, 1'b1);
    @(negedge HCLK);
    chk("mis w1 rsp_valid", rsp_valid_o, 1'b1);
    chk("mis w1 rsp_err", rsp_err_o, 1'b0);
    @(negedge HCLK);

    // The slave returns ERROR for a write. A reset then arrives during the
    // data phase of the following read.
    req_i = 1'b1; req_we_i = 1'b1; req_size_i = 3'd2;
    req_addr_i = 8'h20; req_wdata_i = 32'h55AA55AA;
    @(negedge HCLK);
    req_we_i = 1'b0; req_addr_i = 8'h24;
    @(negedge HCLK);
    req_i = 1'b0;
    chk("err hwdata", HWDATA, 32'h55AA55AA);
    HREADY = 1'b0; HRESP = 1'b1;
    #1 chk("err ready low", req_ready_o, 1'b0);
    @(negedge HCLK);
    chk("err wait rsp_valid", rsp_valid_o, 1'b0);
    chk("err ap held", HTRANS, 2'b10);
    chk("err ap haddr", HADDR, 8'h24);
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("err rsp_valid", rsp_valid_o, 1'b1);
    chk("err rsp_err", rsp_err_o, 1'b1);
    chk("err rsp_rdata", rsp_rdata_o, 32'h0);
    HRESP = 1'b0; HRDATA = 32'h99999999;
    HRESETn = 1'b0;
    #1;
    chk("arst htrans", HTRANS, 2'b00);
    chk("arst hsel", HSEL, 1'b0);
    chk("arst haddr", HADDR, 8'h00);
    chk("arst hwrite", HWRITE, 1'b0);
    chk("arst hsize", HSIZE, 3'd0);
    chk("arst hwdata", HWDATA, 32'h0);
    chk("arst rsp_valid", rsp_valid_o, 1'b0);
    chk("arst rsp_err", rsp_err_o, 1'b0);
    chk("arst rsp_rdata", rsp_rdata_o, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      chk($sformatf("post-rst c%0d rsp_valid", c), rsp_valid_o, 1'b0);
      chk($sformatf("post-rst c%0d htrans", c), HTRANS, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
